rv32i_lsu: RTL and testbench

// - MEM stage directly downstream of the EX-stage ALU.
// - Takes the ALU result as the effective address and rs2 data as store data.
// - Runs a req/ack transaction on the data-memory port.
// - Aligns and sign/zero-extends load data.
// - Registers the write-back bundle for the WB stage (acts as the MEM/WB register).
// - Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/rv32i_lsu_pkg.sv | 21 ++
 rtl/rv32i_load_align.sv | 28 ++
 rtl/rv32i_lsu.sv | 164 ++++++++++++++++
 tb/tb_rv32i_lsu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Shared types, funct3 codes and byte-enable helper for the RV32I load/store unit.
package rv32i_lsu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY} lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Size comes from funct3[1:0]; the sign bit funct3[2] does not affect lanes.
  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << addr_lo;
      2'b01:   return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero-extends it.
module rv32i_load_align
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      LSU_B:   data_o = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      LSU_H:   data_o = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      LSU_BU:  data_o = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      LSU_HU:  data_o = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// MEM stage: issues req/ack data-memory accesses, aligns load data and acts as the
// MEM/WB register, stalling upstream while an access is outstanding.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_store_data,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [4:0]       i_rd,
  input  logic             i_reg_write,
  output logic             o_stall,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [3:0]       o_dmem_be,
  output logic [WIDTH-1:0] o_dmem_wdata,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_wb_valid,
  output logic             o_wb_we,
  output logic [4:0]       o_wb_rd,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_fault,
  output logic [WIDTH-1:0] o_fault_addr
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  lsu_state_t       state_q;
  logic [CntW-1:0]  cnt_q;
  logic             req_q, we_q, reg_write_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]       be_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic             wb_valid_q, wb_we_q, fault_q;
  logic [4:0]       wb_rd_q;
  logic [WIDTH-1:0] wb_data_q, fault_addr_q;

  logic             is_mem, f3_ok, misaligned, req_fault, accept, timeout;
  logic [WIDTH-1:0] store_rep, load_data;

  assign is_mem = i_valid & (i_mem_read | i_mem_write);

  always_comb begin
    f3_ok = 1'b0;
    case (i_funct3)
      LSU_B, LSU_H, LSU_W: f3_ok = 1'b1;
      LSU_BU, LSU_HU:      f3_ok = ~i_mem_write;
      default:             f3_ok = 1'b0;
    endcase
    misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                 ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));
    case (i_funct3[1:0])
      2'b00:   store_rep = {(WIDTH/8){i_store_data[7:0]}};
      2'b01:   store_rep = {(WIDTH/16){i_store_data[15:0]}};
      default: store_rep = i_store_data;
    endcase
  end

  assign req_fault = is_mem & (~f3_ok | misaligned);
  assign accept    = (state_q == IDLE) & is_mem & ~req_fault;
  assign timeout   = (state_q == BUSY) & ~i_dmem_ack & (ACK_TIMEOUT != 0) & (cnt_q == CntMax);
  // Stall drops in the ack or timeout cycle so the next instruction issues gap-free.
  assign o_stall   = ~i_rst & (accept | ((state_q == BUSY) & ~i_dmem_ack & ~timeout));

  rv32i_load_align #(
    .WIDTH(WIDTH)
  ) u_load_align (
    .rdata_i  (i_dmem_rdata),
    .addr_lo_i(addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (i_valid & ~is_mem) begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= i_reg_write;
            wb_rd_q    <= i_rd;
            wb_data_q  <= i_alu_result;
          end else if (req_fault) begin
            fault_q      <= 1'b1;
            fault_addr_q <= i_addr;
          end else if (accept) begin
            state_q     <= BUSY;
            req_q       <= 1'b1;
            we_q        <= i_mem_write;
            addr_q      <= i_addr;
            be_q        <= lsu_be(i_funct3, i_addr[1:0]);
            wdata_q     <= store_rep;
            funct3_q    <= i_funct3;
            rd_q        <= i_rd;
            reg_write_q <= i_reg_write;
          end
        end
        BUSY: begin
          if (i_dmem_ack) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= ~we_q & reg_write_q;
            wb_rd_q    <= rd_q;
            if (!we_q) wb_data_q <= load_data;
          end else if (timeout) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed scenarios plus randomized traffic
// against a byte-level reference model.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_read, mem_write, reg_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, alu_result;
  logic [4:0]  rd;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_lsu #(
    .WIDTH      (32),
    .ACK_TIMEOUT(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_mem_read  (mem_read),
    .i_mem_write (mem_write),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_store_data(store_data),
    .i_alu_result(alu_result),
    .i_rd        (rd),
    .i_reg_write (reg_write),
    .o_stall     (stall),
    .o_dmem_req  (dmem_req),
    .o_dmem_we   (dmem_we),
    .o_dmem_addr (dmem_addr),
    .o_dmem_be   (dmem_be),
    .o_dmem_wdata(dmem_wdata),
    .i_dmem_ack  (dmem_ack),
    .i_dmem_rdata(dmem_rdata),
    .o_wb_valid  (wb_valid),
    .o_wb_we     (wb_we),
    .o_wb_rd     (wb_rd),
    .o_wb_data   (wb_data),
    .o_fault     (fault),
    .o_fault_addr(fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, lane patterns, load extension.
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit exp_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 > 3'd5) return 1'b1;
    if (wr && f3 >= 3'd4) return 1'b1;
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= int'(off)) && (i < int'(off) + acc_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % acc_size(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] v;
    int          sz;
    sz = acc_size(f3);
    v  = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(int'(off) + i) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  task automatic idle_inputs();
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    funct3 = '0; addr = '0; store_data = '0; alu_result = '0; rd = '0;
  endtask

  // Caller is just after a rising edge with the DUT idle; returns just after the edge
  // that follows the ack cycle.
  task automatic mem_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                        input logic [4:0] r, input bit rw, output int stalls,
                        output logic [3:0] be_seen, output logic [31:0] wd_seen);
    valid = 1'b1; mem_read = ~wr; mem_write = wr; funct3 = f3; addr = a;
    store_data = sd; rd = r; reg_write = rw; alu_result = $urandom;
    dmem_ack = 1'b0;
    #1;
    check("accept_stall", stall, 1'b1);
    stalls = int'(stall);
    be_seen = '0; wd_seen = '0;
    for (int k = 0; k <= delay; k++) begin
      @(posedge clk); #1;
      check("busy_req", dmem_req, 1'b1);
      check("busy_we", dmem_we, wr);
      check("busy_addr", dmem_addr, a & ~32'd3);
      check("busy_be", dmem_be, exp_be(f3, a[1:0]));
      if (wr) check("busy_wdata", dmem_wdata, exp_wdata(f3, sd));
      check("busy_wb_valid", wb_valid, 1'b0);
      if (k == 0) begin be_seen = dmem_be; wd_seen = dmem_wdata; end
      if (k == delay) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        check("ack_stall", stall, 1'b0);
      end else begin
        check("wait_stall", stall, 1'b1);
      end
      stalls += int'(stall);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    idle_inputs();
    check("post_req", dmem_req, 1'b0);
    check("wb_valid", wb_valid, 1'b1);
    check("wb_we", wb_we, wr ? 1'b0 : rw);
    check("wb_rd", wb_rd, r);
    if (!wr) check("wb_data", wb_data, exp_load(rdata, a[1:0], f3));
    check("wb_fault", fault, 1'b0);
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] r, input bit rw);
    valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_result = res; rd = r; reg_write = rw;
    funct3 = $urandom; addr = $urandom;
    #1;
    check("alu_stall", stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_we", wb_we, rw);
    check("alu_wb_rd", wb_rd, r);
    check("alu_wb_data", wb_data, res);
  endtask

  task automatic fault_op(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    valid = 1'b1; mem_read = ~wr; mem_write = wr; funct3 = f3; addr = a;
    store_data = $urandom; rd = 5'd7; reg_write = 1'b1;
    #1;
    check("flt_stall", stall, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    check("flt_pulse", fault, 1'b1);
    check("flt_addr", fault_addr, a);
    check("flt_req", dmem_req, 1'b0);
    check("flt_wb_valid", wb_valid, 1'b0);
    @(posedge clk); #1;
    check("flt_pulse_end", fault, 1'b0);
  endtask

  initial begin
    int          st;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    idle_inputs();
    #12;
    check("rst_req", dmem_req, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_wb_data", wb_data, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    mem_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 5'd3, 1'b1, st, be_s, wd_s);
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_be", be_s, 4'b1111);
    check("lw_stalls", st, 1);

    mem_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 3, 5'd4, 1'b1, st, be_s, wd_s);
    check("lb_data", wb_data, 32'hFFFFFF80);
    check("lb_stalls", st, 4);
    mem_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 5'd5, 1'b1, st, be_s, wd_s);
    check("lbu_data", wb_data, 32'h00000080);

    mem_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2, 5'd6, 1'b1, st, be_s, wd_s);
    check("sh_be", be_s, 4'b1100);
    check("sh_wdata", wd_s, 32'hABCDABCD);

    fault_op(1'b0, 3'b010, 32'h101);
    fault_op(1'b0, 3'b011, 32'h200);
    fault_op(1'b1, 3'b100, 32'h204);

    // Ack never returned: four request cycles, then a fault pulse.
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; rd = 5'd9; reg_write = 1'b1;
    #1;
    check("to_accept_stall", stall, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("to_req", dmem_req, 1'b1);
      check("to_stall", stall, (k < 4) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    idle_inputs();
    check("to_fault", fault, 1'b1);
    check("to_fault_addr", fault_addr, 32'h300);
    check("to_req_drop", dmem_req, 1'b0);
    check("to_wb_valid", wb_valid, 1'b0);
    alu_op(32'hCAFE0001, 5'd10, 1'b1);

    // Asynchronous reset while an access is outstanding.
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; rd = 5'd11; reg_write = 1'b1;
    @(posedge clk); #1;
    check("rb_req", dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rb_req_async", dmem_req, 1'b0);
    check("rb_stall", stall, 1'b0);
    check("rb_be", dmem_be, 4'd0);
    check("rb_addr", dmem_addr, 32'd0);
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    check("late_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_wb", wb_valid, 1'b0);
    check("late_ack_req", dmem_req, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int          kind;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        alu_op($urandom, 5'($urandom), 1'($urandom));
      end else begin
        if (kind == 3) begin
          wr = 1'($urandom);
          f3 = 3'($urandom);
          a  = $urandom & 32'h0000FFFF;
        end else begin
          wr = (kind == 2);
          case ($urandom_range(0, wr ? 2 : 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
          a = ($urandom & 32'h0000FFFC) | 32'($urandom_range(0, 3) & ~(acc_size(f3) - 1));
        end
        if (exp_fault(wr, f3, a)) fault_op(wr, f3, a);
        else mem_op(wr, f3, a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom),
                    1'($urandom), st, be_s, wd_s);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
